// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and FIFO-buffered LSU writebacks onto the regfile write port; `WB_BYPASS_EN adds forwarding outputs
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int MAX_STARVE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_sel_i,
    input  logic [31:0]                alu_data_i,
    output logic                       alu_stall_o,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [4:0]                 lsu_sel_i,
    input  logic [31:0]                lsu_data_i,
    output logic                       we_o,
    output logic [4:0]                 sel_rd_o,
    output logic [31:0]                rd_o,
    output logic [$clog2(DEPTH):0]     pending_o
`ifdef WB_BYPASS_EN
    ,
    output logic                       fwd_valid_o,
    output logic [4:0]                 fwd_sel_o,
    output logic [31:0]                fwd_data_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(MAX_STARVE + 1);

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic [4:0]    sel_q, sel_d;
    logic [31:0]   data_q, data_d;
    logic          force_drain, alu_win, pop, push, win_v;
    logic [36:0]   win;

    // Arbitrate from registered state and compute next FIFO/starve/output values
    always_comb begin
        force_drain = (count_q != '0) && (starve_q == SW'(MAX_STARVE));
        alu_win     = alu_valid_i && !force_drain;
        pop         = !alu_win && (count_q != '0);
        push        = lsu_valid_i && (count_q != CW'(DEPTH));
        lsu_ready_o = !rst_n || (count_q != CW'(DEPTH));
        alu_stall_o = rst_n && force_drain && alu_valid_i;
        win_v       = alu_win || pop;
        win         = alu_win ? {alu_sel_i, alu_data_i} : mem_q[rd_ptr_q];
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        starve_d    = (pop || count_q == '0) ? '0 :
                      (starve_q == SW'(MAX_STARVE)) ? starve_q : starve_q + 1'b1;
        we_d        = win_v && (win[36:32] != 5'd0);
        sel_d       = win_v ? win[36:32] : sel_q;
        data_d      = win_v ? win[31:0] : data_q;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {lsu_sel_i, lsu_data_i};
    end

    assign we_o      = we_q;
    assign sel_rd_o  = sel_q;
    assign rd_o      = data_q;
    assign pending_o = count_q;
`ifdef WB_BYPASS_EN
    assign fwd_valid_o = we_q && rst_n;
    assign fwd_sel_o   = sel_q;
    assign fwd_data_o  = data_q;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer side of the register-file write port; drives the regfile's sel_rd/rd/we inputs.
- Merges two writeback sources:
  - single-cycle ALU results, which have priority and no backpressure;
  - multi-cycle LSU results, buffered in a small FIFO behind a valid/ready handshake.
- Bounds LSU starvation by stalling the ALU for one cycle when needed.
- Sits between the execute/memory stages and the regfile.

Parameters:
- DEPTH, 4, LSU result FIFO entries; power of two, ≥2.
- MAX_STARVE, 3, consecutive ALU-won cycles with non-empty FIFO before a forced LSU drain.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- alu_valid_i  input  1  ALU result present this cycle.
- alu_sel_i  input  5  ALU destination register.
- alu_data_i  input  32  ALU result.
- alu_stall_o  output  1  ALU result not taken this cycle; upstream holds it.
- lsu_valid_i  input  1  LSU result offered.
- lsu_ready_o  output  1  FIFO can accept.
- lsu_sel_i  input  5  LSU destination register.
- lsu_data_i  input  32  LSU result.
- we_o  output  1  to regfile we_i.
- sel_rd_o  output  5  to regfile sel_rd_i.
- rd_o  output  32  to regfile rd_i.
- pending_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous; all state clears on the clk edge with rst_n=0.
  - we_o=0, sel_rd_o=0, rd_o=0, pending_o=0, starve counter=0, FIFO empty.
  - lsu_ready_o=1 and alu_stall_o=0 whenever rst_n=0 or immediately after reset.
  - Reset mid-operation discards all FIFO contents; no write is issued for them.
- LSU push:
  - Accepted on an edge where lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = (count != DEPTH), from registered count only.
  - No same-cycle pass-through; a push into a full FIFO is never accepted, even while popping.
- Selection each cycle (combinational, from registered state):
  - force = (count != 0) && (starve == MAX_STARVE).
  - alu_stall_o = force && alu_valid_i.
  - ALU wins if alu_valid_i && !force; else FIFO head wins if count != 0; else idle.
- Starve counter:
  - Increments when ALU wins with count != 0.
  - Clears when the FIFO pops or count == 0.
  - Saturates at MAX_STARVE.
- Output register (latency 1): on the edge after selection:
  - we_o = winner present && winner sel != 0;
  - sel_rd_o / rd_o = winner's sel/data;
  - idle → we_o=0, sel_rd_o/rd_o hold previous values.
- x0 writes: the entry is consumed (pop/ALU accept) but we_o=0.
- Simultaneous push and pop: count unchanged.
- Pointer wrap: modulo DEPTH.
- Ordering: LSU results written in arrival order. ALU vs LSU ordering is not guaranteed; the scheduler must not issue both to the same rd in flight (not checked here).
- pending_o reflects the registered count.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs fwd_valid_o (1), fwd_sel_o (5), fwd_data_o (32).
  - They are combinational copies of we_o, sel_rd_o, rd_o.
  - Decode uses them to forward the write landing this cycle, covering the regfile's registered-read one-cycle gap.
  - fwd_valid_o=0 during reset.
- Undefined: these ports do not exist; no other behaviour changes.

Test Plan:
- ALU-only: alu_valid_i=1, sel=5, data=32'hDEADBEEF for 1 cycle → next cycle we_o=1, sel_rd_o=5, rd_o=32'hDEADBEEF; following cycle we_o=0.
- FIFO fill, ALU idle:
  - Push 5 LSU results (sel 1..5, data 32'h100..32'h104) with alu_valid_i=0, DEPTH=4.
  - lsu_ready_o stays 1 throughout: the FIFO pops each cycle, so it never fills.
  - Writes appear in order 1..5, one per cycle, each 1 cycle after push+1.
- Starvation guard:
  - Preload 2 LSU entries, then hold alu_valid_i=1 continuously.
  - ALU wins 3 cycles, 4th cycle alu_stall_o=1 and LSU entry 1 is written.
  - Counter clears; pattern repeats until the FIFO is empty.
- Full backpressure:
  - alu_valid_i held 1, MAX_STARVE large; push 4 LSU results.
  - lsu_ready_o=0, pending_o=4; a 5th lsu_valid_i is not accepted until the first pop.
- x0 drop: ALU sel=0 data=32'h1234 → we_o stays 0; LSU sel=0 entry pops (pending_o decrements) with we_o=0.
- Reset mid-operation: 3 entries pending, rst_n=0 one cycle → pending_o=0, we_o=0, lsu_ready_o=1; no writes for the discarded entries appear afterward.
